// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions used by the register file, the top-level port mux
// and the register-file transfer controller.
//   NUM_REGS     - number of general-purpose registers (power of two)
//   DATA_W       - register width
//   IDX_W        - register index width, log2(NUM_REGS)
//   xfer_state_t - transfer controller FSM states
package slc3_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_SEL,
    RD_OUT,
    WR,
    FIN
  } xfer_state_t;

endpackage

// File: rtl/regfile_xfer_ctrl.sv
// Register-file transfer controller. Acts as a bus master on the register
// file ports: walks R0..R(NUM_REGS-1) either dumping each register onto a
// valid/ready output stream, or restoring each register from a valid/ready
// input stream. While Busy is high the top level muxes SR1_sel, DR_sel,
// LD_REG and Wr_data onto the register file in place of the datapath.
//
// Ports:
//   Clk, Reset_n            clock (rising edge), async active-low reset
//   Start_dump, Start_load  one-cycle transfer requests, sampled in IDLE only
//   Abort                   cancel the transfer in progress (no Done)
//   Busy, Done              ownership flag, one-cycle completion pulse
//   SR1_sel, SR1_data       register-file read port
//   DR_sel, LD_REG, Wr_data register-file write port
//   Dout, Dout_idx, Dout_valid, Dout_ready   dump stream
//   Din, Din_valid, Din_ready                load stream
module regfile_xfer_ctrl #(
  parameter int NUM_REGS = slc3_pkg::NUM_REGS,
  parameter int DATA_W   = slc3_pkg::DATA_W,
  parameter int IDX_W    = slc3_pkg::IDX_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start_dump,
  input  logic              Start_load,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [IDX_W-1:0]  SR1_sel,
  input  logic [DATA_W-1:0] SR1_data,
  output logic [IDX_W-1:0]  DR_sel,
  output logic              LD_REG,
  output logic [DATA_W-1:0] Wr_data,
  output logic [DATA_W-1:0] Dout,
  output logic [IDX_W-1:0]  Dout_idx,
  output logic              Dout_valid,
  input  logic              Dout_ready,
  input  logic [DATA_W-1:0] Din,
  input  logic              Din_valid,
  output logic              Din_ready
);

  import slc3_pkg::*;

  xfer_state_t      state;
  logic [IDX_W-1:0] idx;
  logic             last_idx;

  // The terminal check happens before any increment, so idx never wraps
  // inside a transfer.
  assign last_idx = (idx == IDX_W'(NUM_REGS - 1));

  // idx is forced back to 0 on every return to IDLE, so the select lines
  // read 0 there without extra muxing.
  assign SR1_sel = idx;
  assign DR_sel  = idx;

  // The write strobe follows Din_valid in the same cycle so the register file
  // commits on the very edge that completes the handshake; this also means a
  // beat presented alongside Abort still lands.
  assign LD_REG  = (state == WR) && Din_valid;
  assign Wr_data = (state == WR) ? Din : '0;

  // Transfer FSM with registered status/stream flags. Abort takes priority
  // over any handshake decision; the captured dump word is only loaded in
  // RD_SEL so it stays stable for the whole RD_OUT wait.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Dout       <= '0;
      Dout_idx   <= '0;
      Dout_valid <= 1'b0;
      Din_ready  <= 1'b0;
    end else if (Abort && (state != IDLE)) begin
      state      <= IDLE;
      idx        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Dout_valid <= 1'b0;
      Din_ready  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_dump) begin
            state <= RD_SEL;
            idx   <= '0;
            Busy  <= 1'b1;
          end else if (Start_load) begin
            state     <= WR;
            idx       <= '0;
            Busy      <= 1'b1;
            Din_ready <= 1'b1;
          end
        end
        RD_SEL: begin
          Dout       <= SR1_data;
          Dout_idx   <= idx;
          Dout_valid <= 1'b1;
          state      <= RD_OUT;
        end
        RD_OUT: begin
          if (Dout_ready) begin
            Dout_valid <= 1'b0;
            if (last_idx) begin
              state <= FIN;
              Done  <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= RD_SEL;
            end
          end
        end
        WR: begin
          if (Din_valid) begin
            if (last_idx) begin
              state     <= FIN;
              Done      <= 1'b1;
              Din_ready <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          idx   <= '0;
          Busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          idx        <= '0;
          Busy       <= 1'b0;
          Dout_valid <= 1'b0;
          Din_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Testbench for regfile_xfer_ctrl. Hosts a behavioural register file on the
// controller's ports and a reference copy of the register contents that is
// updated only from the stream beats the bench itself sends. Dump beats are
// compared against that reference, timing against the expected beat cadence.
module tb_regfile_xfer_ctrl;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int IDX_W    = 3;

  logic              clk;
  logic              reset_n;
  logic              start_dump;
  logic              start_load;
  logic              abort;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  sr1_sel;
  logic [DATA_W-1:0] sr1_data;
  logic [IDX_W-1:0]  dr_sel;
  logic              ld_reg;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] dout;
  logic [IDX_W-1:0]  dout_idx;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  logic [DATA_W-1:0] rf     [NUM_REGS];
  logic [DATA_W-1:0] ref_rf [NUM_REGS];
  logic              preload;
  int                ld_count;
  int                total_count;
  int                bad_count;

  regfile_xfer_ctrl #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) dut (
    .Clk       (clk),
    .Reset_n   (reset_n),
    .Start_dump(start_dump),
    .Start_load(start_load),
    .Abort     (abort),
    .Busy      (busy),
    .Done      (done),
    .SR1_sel   (sr1_sel),
    .SR1_data  (sr1_data),
    .DR_sel    (dr_sel),
    .LD_REG    (ld_reg),
    .Wr_data   (wr_data),
    .Dout      (dout),
    .Dout_idx  (dout_idx),
    .Dout_valid(dout_valid),
    .Dout_ready(dout_ready),
    .Din       (din),
    .Din_valid (din_valid),
    .Din_ready (din_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write on the rising edge.
  assign sr1_data = rf[sr1_sel];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 16'h1000 + 16'(i);
    end else if (ld_reg) begin
      rf[dr_sel] <= wr_data;
      ld_count   <= ld_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic dump_req, input logic load_req);
    start_dump = dump_req;
    start_load = load_req;
  endtask

  // mode 0: sink always ready, 1: random ready, 2: ready low 3 cycles at R4.
  task automatic runDump(input int mode, input bit with_load, output int done_cycle);
    int beat;
    int low_left;
    int ld_start;
    bit exp_valid;
    bit seen_low;
    bit finished;
    beat = 0; low_left = 0; ld_start = ld_count;
    exp_valid = 0; seen_low = 0; finished = 0; done_cycle = -1;
    @(negedge clk);
    applyStimulus(1'b1, with_load);
    dout_ready = 1'b1;
    for (int cycle = 1; cycle <= 300 && !finished; cycle++) begin
      @(negedge clk);
      applyStimulus(1'b0, with_load && (cycle == 5));
      if (beat == NUM_REGS) begin
        checkOutput("dump_done", done, 1);
        checkOutput("dump_fin_busy", busy, 1);
        done_cycle = cycle;
        finished   = 1;
      end else begin
        checkOutput("dump_done_early", done, 0);
        checkOutput("dump_busy", busy, 1);
        checkOutput("dump_valid", dout_valid, exp_valid);
        checkOutput("dump_sr1_sel", sr1_sel, beat);
        if (exp_valid) begin
          checkOutput("dump_idx", dout_idx, beat);
          checkOutput("dump_data", dout, ref_rf[beat]);
        end
        if (mode == 0) begin
          dout_ready = 1'b1;
        end else if (mode == 1) begin
          dout_ready = 1'($urandom_range(0, 1));
        end else begin
          if (exp_valid && beat == 4 && !seen_low) begin
            seen_low = 1;
            low_left = 3;
          end
          if (low_left > 0) begin
            dout_ready = 1'b0;
            low_left--;
          end else begin
            dout_ready = 1'b1;
          end
        end
        if (exp_valid && dout_ready) begin
          exp_valid = 0;
          beat++;
        end else if (!exp_valid) begin
          exp_valid = 1;
        end
      end
    end
    if (!finished) checkOutput("dump_timeout", 0, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    checkOutput("dump_idle_busy", busy, 0);
    checkOutput("dump_idle_done", done, 0);
    checkOutput("dump_no_ld", ld_count - ld_start, 0);
  endtask

  // mode 0: Din = A0A0+n with valid held high, 1: random data and valid.
  // abort_after >= 0 raises Abort once that many registers are written.
  task automatic runLoad(input int mode, input int abort_after, output int done_cycle);
    logic [DATA_W-1:0] data [NUM_REGS];
    int w;
    int ld_start;
    bit finished;
    for (int i = 0; i < NUM_REGS; i++)
      data[i] = (mode == 0) ? 16'hA0A0 + 16'(i) : 16'($urandom);
    w = 0; ld_start = ld_count; finished = 0; done_cycle = -1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    for (int cycle = 1; cycle <= 300 && !finished; cycle++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      din_valid = 1'b0;
      if (w == NUM_REGS) begin
        checkOutput("load_done", done, 1);
        checkOutput("load_fin_busy", busy, 1);
        done_cycle = cycle;
        finished   = 1;
        @(negedge clk);
        checkOutput("load_idle_busy", busy, 0);
        checkOutput("load_idle_done", done, 0);
      end else if (w == abort_after) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_din_ready", din_ready, 0);
        finished = 1;
      end else begin
        checkOutput("load_done_early", done, 0);
        checkOutput("load_busy", busy, 1);
        checkOutput("load_din_ready", din_ready, 1);
        checkOutput("load_dr_sel", dr_sel, w);
        din_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        din       = data[w];
        #1;
        checkOutput("load_ld_reg", ld_reg, din_valid);
        if (din_valid) begin
          checkOutput("load_wr_data", wr_data, data[w]);
          ref_rf[w] = data[w];
          w++;
        end
      end
    end
    if (!finished) checkOutput("load_timeout", 0, 1);
    din_valid = 1'b0;
    checkOutput("load_ld_count", ld_count - ld_start, w);
    for (int i = 0; i < NUM_REGS; i++) checkOutput("load_rf", rf[i], ref_rf[i]);
  endtask

  initial begin
    int dc;
    bit found;
    total_count = 0; bad_count = 0; ld_count = 0;
    reset_n = 1'b0; preload = 1'b1; abort = 1'b0;
    applyStimulus(1'b0, 1'b0);
    dout_ready = 1'b0; din = 16'hFFFF; din_valid = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = 16'h1000 + 16'(i);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_dout_idx", dout_idx, 0);
    checkOutput("rst_dout_valid", dout_valid, 0);
    checkOutput("rst_din_ready", din_ready, 0);
    checkOutput("rst_ld_reg", ld_reg, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_sel", {sr1_sel, dr_sel}, 0);
    din = '0; din_valid = 1'b0;
    reset_n = 1'b1;

    runDump(0, 1'b0, dc);
    checkOutput("dump_done_cycle", dc, 17);

    runLoad(0, -1, dc);
    checkOutput("load_done_cycle", dc, 9);
    runDump(0, 1'b0, dc);

    runDump(2, 1'b0, dc);
    runDump(0, 1'b1, dc);

    runLoad(0, 3, dc);
    runDump(1, 1'b0, dc);

    for (int r = 0; r < 4; r++) begin
      runLoad(1, -1, dc);
      runDump(1, 1'b0, dc);
    end

    // Asynchronous reset mid-dump while R5 is on the stream.
    found = 0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    dout_ready = 1'b1;
    for (int cycle = 0; cycle < 40 && !found; cycle++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      if (dout_valid && dout_idx == 3'd5) found = 1;
    end
    checkOutput("rst_mid_reach_r5", found, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_valid", dout_valid, 0);
    checkOutput("rst_mid_dout", dout, 0);
    checkOutput("rst_mid_dout_idx", dout_idx, 0);
    checkOutput("rst_mid_sr1_sel", sr1_sel, 0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_idle", busy, 0);
    runDump(0, 1'b0, dc);
    checkOutput("rst_redump_done_cycle", dc, 17);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
